// File: rtl/com_beacon_scheduler.sv
// com_beacon_scheduler: counts timer ticks to a programmed interval, then raises a beacon request with sequence number.
// Optional random pre-request delay (LFSR + JITTER_MAX register) when COM_SCHED_JITTER_EN is defined.
module com_beacon_scheduler #(
  parameter int IV_W   = 8,
  parameter int MISS_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [15:0] tx_seq
);
`ifdef COM_SCHED_JITTER_EN
  typedef enum logic [1:0] {IDLE, COUNT, JITTER, REQ} state_t;
  logic [7:0] lfsr_q, jmax_q, jmax_d, dly_q;
`else
  typedef enum logic [1:0] {IDLE, COUNT, REQ} state_t;
`endif
  state_t state_q;
  logic tx_req_q, pending_q, shv_q, shv_d, done_q, done_d, missed_q, missed_d;
  logic en_q, ide_q, ime_q;
  logic [2:0] ctrl_d;
  logic [15:0] tx_seq_q, seq_q, seq_d, shadow_q, shadow_d, readdata_q, readdata_d;
  logic [IV_W-1:0] interval_q, interval_d, tick_cnt_q, tick_cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic wr, running, in_req, in_jit, expire, ack_evt, miss_evt, seq_wr;
  assign wr       = chipselect & ~write_n;
  assign running  = state_q != IDLE;
  assign in_req   = state_q == REQ;
`ifdef COM_SCHED_JITTER_EN
  assign in_jit   = state_q == JITTER;
`else
  assign in_jit   = 1'b0;
`endif
  assign expire   = running & en_q & tick_in & (tick_cnt_q <= IV_W'(1));
  assign ack_evt  = en_q & in_req & tx_ack;
  assign miss_evt = expire & ((in_req & ~tx_ack) | in_jit);
  assign seq_wr   = wr & (address == 3'd3);
  assign irq      = (done_q & ide_q) | (missed_q & ime_q);
  assign tx_req   = tx_req_q;
  assign tx_seq   = tx_seq_q;
  assign readdata = readdata_q;
  always_comb begin
    tick_cnt_d = (!running || expire) ? interval_q :
                 (en_q & tick_in) ? tick_cnt_q - IV_W'(1) : tick_cnt_q;
    done_d     = ack_evt | (done_q & ~(wr & (address == 3'd0) & writedata[0]));
    missed_d   = miss_evt | (missed_q & ~(wr & (address == 3'd0) & writedata[1]));
    ctrl_d     = (wr && address == 3'd1) ? writedata[2:0] : {ime_q, ide_q, en_q};
    interval_d = (wr && address == 3'd2) ? writedata[IV_W-1:0] : interval_q;
    miss_d     = miss_evt ? miss_q + MISS_W'(miss_q != '1) :
                 (wr && address == 3'd4) ? '0 : miss_q;
    // a SEQ write during a request is parked until the request finishes so tx_seq stays stable
    shv_d      = (seq_wr & in_req) | (shv_q & in_req & ~ack_evt);
    shadow_d   = (seq_wr & in_req) ? writedata : shadow_q;
    seq_d      = ack_evt ? (shv_q ? shadow_q : seq_q + 16'd1) :
                 (seq_wr & ~in_req) ? writedata :
                 (shv_q & ~in_req) ? shadow_q : seq_q;
`ifdef COM_SCHED_JITTER_EN
    jmax_d     = (wr && address == 3'd5) ? writedata[7:0] : jmax_q;
`endif
    case (address)
      3'd0:    readdata_d = {12'd0, running, tx_req_q, missed_q, done_q};
      3'd1:    readdata_d = {13'd0, ime_q, ide_q, en_q};
      3'd2:    readdata_d = 16'(interval_q);
      3'd3:    readdata_d = seq_q;
      3'd4:    readdata_d = 16'(miss_q);
`ifdef COM_SCHED_JITTER_EN
      3'd5:    readdata_d = {8'd0, jmax_q};
`endif
      default: readdata_d = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {done_q, missed_q, en_q, ide_q, ime_q, shv_q} <= '0;
      interval_q <= IV_W'(1);
      tick_cnt_q <= IV_W'(1);
      miss_q     <= '0;
      seq_q      <= '0;
      shadow_q   <= '0;
      readdata_q <= '0;
`ifdef COM_SCHED_JITTER_EN
      jmax_q     <= '0;
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      done_q     <= done_d;
      missed_q   <= missed_d;
      {ime_q, ide_q, en_q} <= ctrl_d;
      interval_q <= interval_d;
      tick_cnt_q <= tick_cnt_d;
      miss_q     <= miss_d;
      seq_q      <= seq_d;
      shv_q      <= shv_d;
      shadow_q   <= shadow_d;
      readdata_q <= readdata_d;
`ifdef COM_SCHED_JITTER_EN
      jmax_q     <= jmax_d;
      lfsr_q     <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !en_q) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_seq_q  <= '0;
      pending_q <= 1'b0;
`ifdef COM_SCHED_JITTER_EN
      if (reset) dly_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: state_q <= COUNT;
        COUNT: if (expire || pending_q) begin
          pending_q <= 1'b0;
`ifdef COM_SCHED_JITTER_EN
          state_q   <= JITTER;
          dly_q     <= lfsr_q & jmax_q;
`else
          state_q   <= REQ;
          tx_req_q  <= 1'b1;
          tx_seq_q  <= seq_q;
`endif
        end
`ifdef COM_SCHED_JITTER_EN
        JITTER: if (dly_q == 8'd0) begin
          state_q  <= REQ;
          tx_req_q <= 1'b1;
          tx_seq_q <= seq_q;
        end else dly_q <= dly_q - 8'd1;
`endif
        REQ: if (tx_ack) begin
          state_q   <= COUNT;
          tx_req_q  <= 1'b0;
          pending_q <= expire;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
